// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared constants for the fetch stage: PC-source codes driven by control,
// the canonical NOP word, the fetch FSM state encodings and the slot record.
package fetch_unit_pkg;

   // PC source codes (control -> fetch)
   localparam logic [2:0] PC_NEXT            = 3'd0;
   localparam logic [2:0] PC_COND_BRANCH     = 3'd1;
   localparam logic [2:0] PC_INV_COND_BRANCH = 3'd2;
   localparam logic [2:0] PC_ALWAYS_BRANCH   = 3'd3;
   localparam logic [2:0] PC_JALR            = 3'd4;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Fetch FSM state encodings
   localparam logic [1:0] ST_FETCH   = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   // Fetch/decode slot contents
   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
   } slot_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Instruction-memory handshake, one outstanding request.
//   imem_req_o   : request outstanding (fetch -> memory)
//   imem_addr_o  : fetch address, stable while imem_req_o is high
//   imem_valid_i : one-cycle response pulse (memory -> fetch)
//   imem_rdata_i : instruction word, qualified by imem_valid_i
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i;
   logic [31:0] imem_rdata_i;

   modport master (output imem_req_o, imem_addr_o,
                   input  imem_valid_i, imem_rdata_i);
   modport slave  (input  imem_req_o, imem_addr_o,
                   output imem_valid_i, imem_rdata_i);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// fetch_unit_next_pc
// Combinational redirect decode: decides whether the resolving instruction
// redirects the PC and computes the word-aligned target.
//   i_ex_valid   : resolving instruction is real this cycle
//   i_pcsrc      : PC source code
//   i_zero       : ALU zero flag
//   i_ex_pc      : PC of the resolving instruction
//   i_imm        : sign-extended branch/jump offset
//   i_alu_result : rs1+imm for jalr
//   o_taken      : redirect this cycle
//   o_target     : redirect target, bits [1:0] cleared
module fetch_unit_next_pc
   import fetch_unit_pkg::*;
(
   input  logic        i_ex_valid,
   input  logic [2:0]  i_pcsrc,
   input  logic        i_zero,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_alu_result,
   output logic        o_taken,
   output logic [31:0] o_target
);

   logic [31:0] w_branch;
   logic [31:0] w_raw;

   assign w_branch = i_ex_pc + i_imm;

   always_comb begin
      o_taken = 1'b0;
      w_raw   = w_branch;
      if (i_ex_valid) begin
         case (i_pcsrc)
            PC_COND_BRANCH:     o_taken = i_zero;
            PC_INV_COND_BRANCH: o_taken = ~i_zero;
            PC_ALWAYS_BRANCH:   o_taken = 1'b1;
            PC_JALR: begin
               o_taken = 1'b1;
               w_raw   = i_alu_result;
            end
            default:            o_taken = 1'b0;
         endcase
      end
   end

   assign o_target = {w_raw[31:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage: PC register, one-outstanding-request handshake to
// instruction memory, skid buffer and registered fetch/decode slot.
//   clk, rst_n                 : clock, async active-low reset
//   stall_i                    : decode cannot accept, hold the slot
//   ex_valid_i .. alu_result_i : redirect information from execute
//   imem                       : instruction-memory handshake (master side)
//   instr_o, pc_o, pc_plus4_o,
//   instr_valid_o              : fetch/decode slot
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FETCH   | request outstanding at r_pc
// ST_HOLD    | response parked in skid buffer, waiting for stall to drop
// ST_DISCARD | stale request in flight after a redirect, drop its data
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               ex_valid_i,
   input  logic [2:0]         PCSrc_i,
   input  logic               Zero_i,
   input  logic [31:0]        ex_pc_i,
   input  logic [31:0]        ImmExt_i,
   input  logic [31:0]        alu_result_i,
   fetch_unit_if.master       imem,
   output logic [31:0]        instr_o,
   output logic [31:0]        pc_o,
   output logic [31:0]        pc_plus4_o,
   output logic               instr_valid_o
);

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_skid;
   slot_t       r_slot;

   logic        w_taken;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   fetch_unit_next_pc u_next_pc (
      .i_ex_valid   (ex_valid_i),
      .i_pcsrc      (PCSrc_i),
      .i_zero       (Zero_i),
      .i_ex_pc      (ex_pc_i),
      .i_imm        (ImmExt_i),
      .i_alu_result (alu_result_i),
      .o_taken      (w_taken),
      .o_target     (w_target)
   );

   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_skid  <= '0;
         r_slot  <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'd0};
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_taken) begin
                  r_pc         <= w_target;
                  r_slot.valid <= 1'b0;
                  // A response arriving with the redirect retires the old
                  // request, so the new one can start right away.
                  r_state      <= imem.imem_valid_i ? ST_FETCH : ST_DISCARD;
               end else if (imem.imem_valid_i) begin
                  r_pc <= w_pc_plus4;
                  if (stall_i) begin
                     r_skid  <= imem.imem_rdata_i;
                     r_state <= ST_HOLD;
                  end else begin
                     r_slot <= '{valid: 1'b1, instr: imem.imem_rdata_i, pc: r_pc};
                  end
               end else if (!stall_i) begin
                  r_slot.valid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (w_taken) begin
                  r_pc         <= w_target;
                  r_slot.valid <= 1'b0;
                  r_state      <= ST_FETCH;
               end else if (!stall_i) begin
                  // r_pc already advanced past the buffered word
                  r_slot  <= '{valid: 1'b1, instr: r_skid, pc: r_pc - 32'd4};
                  r_state <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (w_taken) begin
                  r_pc         <= w_target;
                  r_slot.valid <= 1'b0;
               end else if (!stall_i) begin
                  r_slot.valid <= 1'b0;
               end
               // Leave as soon as the stale response lands, even when a new
               // redirect arrives in the same cycle; otherwise nothing would
               // ever complete the wait.
               if (imem.imem_valid_i) r_state <= ST_FETCH;
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   // Gated by rst_n so no request is visible while reset is held.
   assign imem.imem_req_o  = rst_n && (r_state == ST_FETCH);
   assign imem.imem_addr_o = r_pc;

   assign instr_o       = r_slot.valid ? r_slot.instr : NOP_INSTR;
   assign pc_o          = r_slot.pc;
   assign pc_plus4_o    = r_slot.pc + 32'd4;
   assign instr_valid_o = r_slot.valid;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, ex_valid_i, Zero_i;
   logic [2:0]  PCSrc_i;
   logic [31:0] ex_pc_i, ImmExt_i, alu_result_i;
   logic [31:0] instr_o, pc_o, pc_plus4_o;
   logic        instr_valid_o;

   fetch_unit_if imem();

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
      .PCSrc_i(PCSrc_i), .Zero_i(Zero_i), .ex_pc_i(ex_pc_i), .ImmExt_i(ImmExt_i),
      .alu_result_i(alu_result_i), .imem(imem), .instr_o(instr_o), .pc_o(pc_o),
      .pc_plus4_o(pc_plus4_o), .instr_valid_o(instr_valid_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model configuration; mem_lat = 0 selects random 1..3 per request
   int          mem_lat = 1;
   logic [31:0] salt    = 32'h0;
   logic        sp_en   = 1'b0;
   logic [31:0] sp_addr = 32'h0;
   logic [31:0] sp_data = 32'h0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (sp_en && a == sp_addr) ? sp_data : (a ^ salt);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // reference redirect rules
   function automatic logic ref_taken(input logic ev, input logic [2:0] src, input logic z);
      if (!ev) return 1'b0;
      return (src == 3'd1 && z) || (src == 3'd2 && !z) || src == 3'd3 || src == 3'd4;
   endfunction

   function automatic logic [31:0] ref_target(input logic [2:0] src, input logic [31:0] epc,
                                              input logic [31:0] imm, input logic [31:0] alu);
      logic [31:0] t;
      t = (src == 3'd4) ? alu : epc + imm;
      return t & 32'hFFFF_FFFC;
   endfunction

   // instruction memory: latches the request, answers after the latency
   initial begin : mem_model
      logic        busy;
      logic [31:0] a;
      int          rem;
      busy = 1'b0; a = '0; rem = 0;
      imem.imem_valid_i = 1'b0;
      imem.imem_rdata_i = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) begin
            busy = 1'b0;
            imem.imem_valid_i = 1'b0;
         end else begin
            if (imem.imem_valid_i) begin
               imem.imem_valid_i = 1'b0;
               busy = 1'b0;
            end
            if (busy && imem.imem_req_o) chk("imem_addr_stable", imem.imem_addr_o, a);
            if (!busy && imem.imem_req_o) begin
               busy = 1'b1;
               a    = imem.imem_addr_o;
               rem  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (busy) begin
               rem--;
               if (rem == 0) begin
                  imem.imem_valid_i = 1'b1;
                  imem.imem_rdata_i = mem_data(a);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      stall_i = 0; ex_valid_i = 0; PCSrc_i = 3'd0; Zero_i = 0;
      ex_pc_i = '0; ImmExt_i = '0; alu_result_i = '0;
   endtask

   // leaves the caller at the negedge where reset was released
   task automatic do_reset(input int lat);
      idle_inputs();
      mem_lat = lat;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req",   imem.imem_req_o,  32'd0);
      chk("rst_addr",  imem.imem_addr_o, 32'h0);
      chk("rst_instr", instr_o,          NOP_INSTR);
      chk("rst_pc",    pc_o,             32'd0);
      chk("rst_pc4",   pc_plus4_o,       32'd4);
      chk("rst_valid", instr_valid_o,    32'd0);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int maxc, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < maxc; k++) begin
         tick();
         if (instr_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      logic        ev;
      logic [2:0]  src;
      logic        z;
      logic [31:0] expc;
      logic [31:0] imm;
      logic [31:0] alu;
      logic        taken;
      logic [31:0] tgt;
   } vec_t;

   vec_t vecs[12];

   initial begin : main
      bit          ok;
      logic [31:0] exp_pc;
      int          consumed;
      logic        tk, v;
      logic [31:0] tg, p, ins, p4;

      vecs[0]  = '{1'b1, 3'd1, 1'b1, 32'h0000_0020, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h0000_0018};
      vecs[1]  = '{1'b1, 3'd1, 1'b0, 32'h0000_0020, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 3'd2, 1'b0, 32'h0000_0100, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0140};
      vecs[3]  = '{1'b1, 3'd2, 1'b1, 32'h0000_0100, 32'h0000_0040, 32'h0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 3'd3, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0010};
      vecs[5]  = '{1'b1, 3'd4, 1'b0, 32'h0,         32'h0,         32'h103, 1'b1, 32'h0000_0100};
      vecs[6]  = '{1'b1, 3'd0, 1'b1, 32'h0000_0080, 32'h0000_0010, 32'h0, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 3'd5, 1'b1, 32'h0000_0080, 32'h0000_0010, 32'h0, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 3'd7, 1'b0, 32'h0000_0080, 32'h0000_0010, 32'h0, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 3'd3, 1'b1, 32'h0000_0040, 32'h0000_0006, 32'h0, 1'b1, 32'h0000_0044};
      vecs[10] = '{1'b0, 3'd3, 1'b1, 32'h0000_0040, 32'h0000_0008, 32'h0, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 3'd1, 1'b1, 32'h8000_0000, 32'h8000_0004, 32'h0, 1'b1, 32'h0000_0004};

      // 1-cycle memory after reset: addresses 0,4,8 and one instruction per cycle
      do_reset(1);
      #1;
      chk("b_req_after_rel",  imem.imem_req_o,  32'd1);
      chk("b_addr_after_rel", imem.imem_addr_o, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("b_valid%0d", k), instr_valid_o,    32'd1);
         chk($sformatf("b_pc%0d", k),    pc_o,             32'(4 * k));
         chk($sformatf("b_instr%0d", k), instr_o,          32'(4 * k));
         chk($sformatf("b_addr%0d", k),  imem.imem_addr_o, 32'(4 * k + 4));
      end

      // latency 3: request held at stable address, slot updates on the pulse
      do_reset(3);
      tick();
      chk("c_req1", imem.imem_req_o, 32'd1); chk("c_addr1", imem.imem_addr_o, 32'h0);
      chk("c_val1", instr_valid_o, 32'd0);
      tick();
      chk("c_req2", imem.imem_req_o, 32'd1); chk("c_addr2", imem.imem_addr_o, 32'h0);
      chk("c_val2", instr_valid_o, 32'd0);
      tick();
      chk("c_val3", instr_valid_o, 32'd1); chk("c_pc3", pc_o, 32'h0);
      chk("c_addr3", imem.imem_addr_o, 32'h4);

      // stall for 4 cycles while 00A00093 arrives -> HOLD, then release
      sp_en = 1'b1; sp_addr = 32'h4; sp_data = 32'h00A0_0093;
      do_reset(1);
      tick();
      @(negedge clk); stall_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("d_req%0d", k),   imem.imem_req_o, 32'd0);
         chk($sformatf("d_pc%0d", k),    pc_o,            32'h0);
         chk($sformatf("d_instr%0d", k), instr_o,         32'h0);
         chk($sformatf("d_valid%0d", k), instr_valid_o,   32'd1);
      end
      @(negedge clk); stall_i = 1'b0;
      tick();
      chk("d_rel_instr", instr_o, 32'h00A0_0093);
      chk("d_rel_pc",    pc_o,    32'h4);
      chk("d_rel_valid", instr_valid_o, 32'd1);
      chk("d_rel_addr",  imem.imem_addr_o, 32'h8);
      sp_en = 1'b0;

      // beq redirect in the same cycle as a stall: flush wins
      do_reset(1);
      tick();
      @(negedge clk);
      stall_i = 1; ex_valid_i = 1; PCSrc_i = PC_COND_BRANCH; Zero_i = 1;
      ex_pc_i = 32'h20; ImmExt_i = 32'hFFFF_FFF8;
      tick();
      chk("e_valid", instr_valid_o, 32'd0);
      chk("e_instr", instr_o, NOP_INSTR);
      chk("e_addr",  imem.imem_addr_o, 32'h18);
      @(negedge clk); idle_inputs();
      tick();
      chk("e_next_pc",    pc_o, 32'h18);
      chk("e_next_valid", instr_valid_o, 32'd1);

      // jalr during an outstanding 3-cycle request -> DISCARD
      do_reset(3);
      tick();
      @(negedge clk);
      ex_valid_i = 1; PCSrc_i = PC_JALR; alu_result_i = 32'h103;
      tick();
      chk("f_req_disc",   imem.imem_req_o, 32'd0);
      chk("f_valid_disc", instr_valid_o,   32'd0);
      @(negedge clk); idle_inputs();
      tick();
      chk("f_req_new",  imem.imem_req_o,  32'd1);
      chk("f_addr_new", imem.imem_addr_o, 32'h100);
      chk("f_dropped",  instr_valid_o,    32'd0);
      wait_valid(8, ok);
      chk("f_wait", 32'(ok), 32'd1);
      chk("f_pc",    pc_o,    32'h100);
      chk("f_instr", instr_o, 32'h100);

      // redirect decode table, steady 1-cycle memory
      do_reset(1);
      tick();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         ex_valid_i = vecs[i].ev; PCSrc_i = vecs[i].src; Zero_i = vecs[i].z;
         ex_pc_i = vecs[i].expc; ImmExt_i = vecs[i].imm; alu_result_i = vecs[i].alu;
         tick();
         chk($sformatf("vec%0d_valid", i), instr_valid_o, 32'(!vecs[i].taken));
         if (vecs[i].taken) begin
            chk($sformatf("vec%0d_addr", i),  imem.imem_addr_o, vecs[i].tgt);
            chk($sformatf("vec%0d_instr", i), instr_o, NOP_INSTR);
         end
         @(negedge clk); idle_inputs();
         tick();
      end

      // PC wrap at the top of the address space
      @(negedge clk);
      ex_valid_i = 1; PCSrc_i = PC_JALR; alu_result_i = 32'hFFFF_FFFF;
      tick();
      chk("g_addr_top", imem.imem_addr_o, 32'hFFFF_FFFC);
      @(negedge clk); idle_inputs();
      tick();
      chk("g_addr_wrap", imem.imem_addr_o, 32'h0);
      chk("g_pc",        pc_o,             32'hFFFF_FFFC);
      chk("g_pc4",       pc_plus4_o,       32'h0);

      // randomized run against the program-order model
      salt = 32'h5A00_0000;
      do_reset(0);
      exp_pc = 32'h0;
      consumed = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         stall_i      = ($urandom_range(0, 9) < 3);
         ex_valid_i   = ($urandom_range(0, 11) == 0);
         PCSrc_i      = 3'($urandom_range(0, 7));
         Zero_i       = 1'($urandom_range(0, 1));
         ex_pc_i      = $urandom;
         ImmExt_i     = 32'($urandom_range(0, 511)) - 32'd256;
         alu_result_i = $urandom;
         tk = ref_taken(ex_valid_i, PCSrc_i, Zero_i);
         tg = ref_target(PCSrc_i, ex_pc_i, ImmExt_i, alu_result_i);
         #2;
         v = instr_valid_o; p = pc_o; ins = instr_o; p4 = pc_plus4_o;
         if (v && !stall_i && !tk) begin
            chk("rnd_pc",    p,   exp_pc);
            chk("rnd_instr", ins, mem_data(exp_pc));
            chk("rnd_pc4",   p4,  exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (tk) exp_pc = tg;
         tick();
         if (tk) begin
            chk("rnd_flush_valid", instr_valid_o, 32'd0);
            chk("rnd_flush_instr", instr_o, NOP_INSTR);
         end
      end
      chk("rnd_progress", 32'(consumed > 40), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
